// File: rtl/elevator_controller.sv
// Three-floor elevator controller: latches floor requests, serves them with a
// direction-preserving sweep, times travel and door dwell, and freezes on SOS.
module elevator_controller #(
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sos_button,
    input  logic weight_sensor,
    input  logic st_floor_button,
    input  logic nd_floor_button,
    input  logic rd_floor_button,
    output logic st_floor_led,
    output logic nd_floor_led,
    output logic rd_floor_led,
    output logic door_status_led,
    output logic sos_led,
    output logic emergency_led,
    output logic weight_led
);

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN} state_t;

    // Floors and requests are one-hot, bit 0 = floor 1, bit 2 = floor 3.
    state_t          state_q, state_d;
    logic [2:0]      floor_q, floor_d;
    logic [2:0]      req_q, req_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_up_q, dir_up_d;
    logic            emerg_q;
    logic            sos_prev_q;
    logic            weight_q;

    logic            sos_edge;
    logic            freeze;
    logic [2:0]      btn;
    logic [2:0]      next_floor;

    function automatic logic [2:0] above_mask(input logic [2:0] f);
        return {f[1] | f[0], f[0], 1'b0};
    endfunction

    function automatic logic [2:0] below_mask(input logic [2:0] f);
        return {1'b0, f[2], f[2] | f[1]};
    endfunction

    assign sos_edge   = sos_button & ~sos_prev_q;
    assign freeze     = emerg_q | sos_edge;
    assign btn        = {rd_floor_button, nd_floor_button, st_floor_button};
    assign next_floor = (state_q == MOVE_DN) ? {1'b0, floor_q[2:1]} : {floor_q[1:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        req_d    = req_q;
        if (!freeze) begin
            req_d = req_q | btn;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (|(req_q & floor_q)) begin
                        state_d = DOOR_OPEN;
                        req_d   = req_d & ~floor_q;
                    end else if (|(req_q & above_mask(floor_q)) &&
                                 (dir_up_q || !(|(req_q & below_mask(floor_q))))) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (|(req_q & below_mask(floor_q))) begin
                        state_d  = MOVE_DN;
                        dir_up_d = 1'b0;
                    end
                end
                MOVE_UP, MOVE_DN: begin
                    if (cnt_q == TRAVEL_LAST) begin
                        cnt_d   = '0;
                        floor_d = next_floor;
                        if (|(req_q & next_floor)) begin
                            state_d = DOOR_OPEN;
                            req_d   = req_d & ~next_floor;
                        end else if (!(|(req_q & ((state_q == MOVE_UP) ? above_mask(next_floor)
                                                                      : below_mask(next_floor))))) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DOOR_OPEN: begin
                    // A press for the open floor is absorbed and just restarts the dwell.
                    req_d = req_d & ~floor_q;
                    if (weight_sensor || |(btn & floor_q)) begin
                        cnt_d = '0;
                    end else if (cnt_q == DOOR_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            floor_q    <= 3'b001;
            req_q      <= '0;
            cnt_q      <= '0;
            dir_up_q   <= 1'b1;
            emerg_q    <= 1'b0;
            // Track the button through reset so a press held across release is not an edge.
            sos_prev_q <= sos_button;
            weight_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            dir_up_q   <= dir_up_d;
            emerg_q    <= emerg_q ^ sos_edge;
            sos_prev_q <= sos_button;
            weight_q   <= weight_sensor;
        end
    end

    assign {rd_floor_led, nd_floor_led, st_floor_led} = floor_q;
    assign door_status_led = (state_q == DOOR_OPEN);
    assign sos_led         = emerg_q;
    assign emergency_led   = emerg_q | (weight_sensor & (state_q == DOOR_OPEN));
    assign weight_led      = weight_q;

    a_floor_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(floor_q));
    a_no_up_at_top: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(state_q == MOVE_UP && floor_q[2]));
    a_no_dn_at_bot: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(state_q == MOVE_DN && floor_q[0]));

endmodule
